// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired control unit for the 8-bit accumulator CPU.
// A one-hot beat register walks the fetch beats F1..F3 and then the execute
// beats E1..E5. The instruction in IR is decoded combinationally into the
// datapath strobes and the ALU select. Memory beats stall while mem_ready
// is low. A HALT instruction freezes the sequencer until rst, and run=0
// holds the current beat with every strobe forced to 0.
// Optional build macro: CTRL_WAIT_TIMEOUT_EN. When it is defined, a memory
// stall that lasts too long raises a sticky bus_err and restarts the fetch
// at F1. When it is undefined, stalls are unbounded and bus_err stays 0.
module ctrl_sequencer #(
    parameter int IW         = 8,
    parameter int WAIT_W     = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [IW-1:0] instr,
    input  logic          z,
    input  logic          mem_ready,
    output logic [7:0]    beat,
    output logic          ar_load,
    output logic          ar_inc,
    output logic          pc_load,
    output logic          pc_inc,
    output logic          dr_load,
    output logic          ir_load,
    output logic          tr_load,
    output logic          r_load,
    output logic          ac_load,
    output logic          ac_load_r,
    output logic          z_load,
    output logic          pc_bus,
    output logic          drl_bus,
    output logic          drh_bus,
    output logic          tr_bus,
    output logic          r_bus,
    output logic          ac_bus,
    output logic          mem_read,
    output logic          mem_write,
    output logic [3:0]    alus,
    output logic          instr_done,
    output logic          halted,
    output logic          illegal,
    output logic          bus_err
);

    localparam logic [7:0]        BEAT_F1  = 8'b0000_0001;
    localparam logic [IW-5:0]     CLS_HALT = (IW-4)'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_LIMIT[WAIT_W-1:0];

    typedef enum logic [2:0] {
        K_NOP, K_LDAC, K_STAC, K_MOVAC, K_MOVR, K_JMP, K_ALU, K_HALT
    } kind_e;

    // Everything one beat can assert.
    typedef struct packed {
        logic       ar_load;
        logic       ar_inc;
        logic       pc_load;
        logic       pc_inc;
        logic       dr_load;
        logic       ir_load;
        logic       tr_load;
        logic       r_load;
        logic       ac_load;
        logic       ac_load_r;
        logic       z_load;
        logic       pc_bus;
        logic       drl_bus;
        logic       drh_bus;
        logic       tr_bus;
        logic       r_bus;
        logic       ac_bus;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alus;
        logic       done;
    } uop_t;

    logic [7:0]        beat_q, beat_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              z_lat_q, z_lat_d;

    logic [IW-5:0] cls_s;
    logic [3:0]    op_s;
    kind_e         kind_s;
    logic [3:0]    alu_sel_s;
    logic          alu_r_s;
    logic          jump_s, jmpz_s, jpnz_s;
    logic          taken_s;
    logic          illegal_s;
    uop_t          raw_s;
    uop_t          out_s;
    logic          active_s;
    logic          mem_beat_s;
    logic          stall_s;
    logic          timeout_s;
    logic          advance_s;

    assign cls_s     = instr[IW-1:4];
    assign op_s      = instr[3:0];
    assign illegal_s = (cls_s != '0) && !((cls_s == CLS_HALT) && (op_s == 4'h0));
    assign taken_s   = jump_s | (jmpz_s & z_lat_q) | (jpnz_s & ~z_lat_q);

    // Instruction decode: class/opcode to instruction kind and ALU select.
    always_comb begin
        kind_s    = K_NOP;
        alu_sel_s = 4'd0;
        alu_r_s   = 1'b0;
        jump_s    = 1'b0;
        jmpz_s    = 1'b0;
        jpnz_s    = 1'b0;
        if (cls_s == '0) begin
            case (op_s)
                4'h0:    kind_s = K_NOP;
                4'h1:    kind_s = K_LDAC;
                4'h2:    kind_s = K_STAC;
                4'h3:    kind_s = K_MOVAC;
                4'h4:    kind_s = K_MOVR;
                4'h5:    begin kind_s = K_JMP; jump_s = 1'b1; end
                4'h6:    begin kind_s = K_JMP; jmpz_s = 1'b1; end
                4'h7:    begin kind_s = K_JMP; jpnz_s = 1'b1; end
                4'h8:    begin kind_s = K_ALU; alu_sel_s = 4'd1; alu_r_s = 1'b1; end
                4'h9:    begin kind_s = K_ALU; alu_sel_s = 4'd2; alu_r_s = 1'b1; end
                4'hA:    begin kind_s = K_ALU; alu_sel_s = 4'd3; end
                4'hB:    begin kind_s = K_ALU; alu_sel_s = 4'd0; end
                4'hC:    begin kind_s = K_ALU; alu_sel_s = 4'd4; alu_r_s = 1'b1; end
                4'hD:    begin kind_s = K_ALU; alu_sel_s = 4'd5; alu_r_s = 1'b1; end
                4'hE:    begin kind_s = K_ALU; alu_sel_s = 4'd7; alu_r_s = 1'b1; end
                4'hF:    begin kind_s = K_ALU; alu_sel_s = 4'd6; end
                default: kind_s = K_NOP;
            endcase
        end else if ((cls_s == CLS_HALT) && (op_s == 4'h0)) begin
            kind_s = K_HALT;
        end else begin
            kind_s = K_NOP;
        end
    end

    // Microcode ROM: the ungated strobes for the current beat and instruction.
    always_comb begin
        raw_s = '0;
        case (beat_q)
            8'b0000_0001: begin
                raw_s.pc_bus  = 1'b1;
                raw_s.ar_load = 1'b1;
            end
            8'b0000_0010: begin
                raw_s.mem_read = 1'b1;
                raw_s.dr_load  = 1'b1;
                raw_s.pc_inc   = 1'b1;
            end
            8'b0000_0100: begin
                raw_s.pc_bus  = 1'b1;
                raw_s.ar_load = 1'b1;
                raw_s.ir_load = 1'b1;
            end
            8'b0000_1000: begin
                case (kind_s)
                    K_LDAC, K_STAC: begin
                        raw_s.mem_read = 1'b1;
                        raw_s.dr_load  = 1'b1;
                        raw_s.ar_inc   = 1'b1;
                        raw_s.pc_inc   = 1'b1;
                    end
                    K_JMP: begin
                        raw_s.mem_read = taken_s;
                        raw_s.dr_load  = taken_s;
                        raw_s.ar_inc   = taken_s;
                    end
                    K_MOVAC: begin
                        raw_s.ac_bus = 1'b1;
                        raw_s.r_load = 1'b1;
                        raw_s.done   = 1'b1;
                    end
                    K_MOVR: begin
                        raw_s.r_bus     = 1'b1;
                        raw_s.ac_load_r = 1'b1;
                        raw_s.done      = 1'b1;
                    end
                    K_ALU: begin
                        raw_s.ac_load = 1'b1;
                        raw_s.z_load  = 1'b1;
                        raw_s.r_bus   = alu_r_s;
                        raw_s.alus    = alu_sel_s;
                        raw_s.done    = 1'b1;
                    end
                    default: raw_s.done = 1'b1;
                endcase
            end
            8'b0001_0000: begin
                case (kind_s)
                    K_LDAC, K_STAC: begin
                        raw_s.mem_read = 1'b1;
                        raw_s.dr_load  = 1'b1;
                        raw_s.tr_load  = 1'b1;
                        raw_s.pc_inc   = 1'b1;
                    end
                    K_JMP: begin
                        raw_s.mem_read = taken_s;
                        raw_s.dr_load  = taken_s;
                        raw_s.tr_load  = taken_s;
                        raw_s.pc_inc   = ~taken_s;
                    end
                    default: raw_s.done = 1'b0;
                endcase
            end
            8'b0010_0000: begin
                case (kind_s)
                    K_LDAC, K_STAC: begin
                        raw_s.drh_bus = 1'b1;
                        raw_s.tr_bus  = 1'b1;
                        raw_s.ar_load = 1'b1;
                    end
                    K_JMP: begin
                        raw_s.drh_bus = taken_s;
                        raw_s.tr_bus  = taken_s;
                        raw_s.pc_load = taken_s;
                        raw_s.pc_inc  = ~taken_s;
                        raw_s.done    = 1'b1;
                    end
                    default: raw_s.done = 1'b0;
                endcase
            end
            8'b0100_0000: begin
                case (kind_s)
                    K_LDAC: begin
                        raw_s.mem_read = 1'b1;
                        raw_s.dr_load  = 1'b1;
                    end
                    K_STAC: begin
                        raw_s.ac_bus  = 1'b1;
                        raw_s.dr_load = 1'b1;
                    end
                    default: raw_s.done = 1'b0;
                endcase
            end
            8'b1000_0000: begin
                case (kind_s)
                    K_LDAC: begin
                        raw_s.drl_bus = 1'b1;
                        raw_s.ac_load = 1'b1;
                        raw_s.alus    = 4'd8;
                        raw_s.done    = 1'b1;
                    end
                    K_STAC: begin
                        raw_s.drl_bus   = 1'b1;
                        raw_s.mem_write = 1'b1;
                        raw_s.done      = 1'b1;
                    end
                    default: raw_s.done = 1'b0;
                endcase
            end
            default: raw_s = '0;
        endcase
    end

    assign active_s   = run & ~halted_q & ~rst;
    assign mem_beat_s = raw_s.mem_read | raw_s.mem_write;
    assign stall_s    = active_s & mem_beat_s & ~mem_ready;
    assign advance_s  = active_s & ~stall_s;

`ifdef CTRL_WAIT_TIMEOUT_EN
    assign timeout_s = stall_s & (wait_q == WAIT_MAX);
`else
    assign timeout_s = 1'b0;
`endif

    // State register: synchronous reset back to F1 with all flags clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= BEAT_F1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
            z_lat_q   <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
            z_lat_q   <= z_lat_d;
        end
    end

    // Next state: advance, stall, or abort the access on a wait timeout.
    always_comb begin
        beat_d    = beat_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = wait_q;
        z_lat_d   = z_lat_q;
        if (timeout_s) begin
            beat_d    = BEAT_F1;
            bus_err_d = 1'b1;
            wait_d    = '0;
        end else if (stall_s) begin
            // Saturate so an unbounded stall cannot wrap the counter.
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end else if (advance_s) begin
            wait_d    = '0;
            // Wrapping on E5 as well keeps the beat one-hot if IR changes.
            beat_d    = (raw_s.done || beat_q[7]) ? BEAT_F1 : {beat_q[6:0], 1'b0};
            z_lat_d   = beat_q[2] ? z : z_lat_q;
            halted_d  = halted_q | (beat_q[3] & (kind_s == K_HALT));
            illegal_d = illegal_q | ((|beat_q[7:3]) & illegal_s);
        end else begin
            beat_d = beat_q;
        end
    end

    // Output gating: idle or timed out -> nothing, stalled -> only the memory strobe.
    always_comb begin
        out_s = '0;
        if (!active_s || timeout_s) begin
            out_s = '0;
        end else if (stall_s) begin
            out_s.mem_read  = raw_s.mem_read;
            out_s.mem_write = raw_s.mem_write;
        end else begin
            out_s = raw_s;
        end
    end

    assign beat       = beat_q;
    assign ar_load    = out_s.ar_load;
    assign ar_inc     = out_s.ar_inc;
    assign pc_load    = out_s.pc_load;
    assign pc_inc     = out_s.pc_inc;
    assign dr_load    = out_s.dr_load;
    assign ir_load    = out_s.ir_load;
    assign tr_load    = out_s.tr_load;
    assign r_load     = out_s.r_load;
    assign ac_load    = out_s.ac_load;
    assign ac_load_r  = out_s.ac_load_r;
    assign z_load     = out_s.z_load;
    assign pc_bus     = out_s.pc_bus;
    assign drl_bus    = out_s.drl_bus;
    assign drh_bus    = out_s.drh_bus;
    assign tr_bus     = out_s.tr_bus;
    assign r_bus      = out_s.r_bus;
    assign ac_bus     = out_s.ac_bus;
    assign mem_read   = out_s.mem_read;
    assign mem_write  = out_s.mem_write;
    assign alus       = out_s.alus;
    assign instr_done = out_s.done;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired control unit for the 8-bit accumulator CPU.
- Generates one-hot timing beats: fetch F1–F3, then execute E1–E5.
- Decodes the IR output and drives the datapath load/inc/bus strobes plus the ALU select.
- Adds three things over the fixed-beat controller: memory wait-state stalls, a HALT instruction, and run gating. The jump condition flag is latched at F3.

Parameters:
- IW, 8: instruction width. Opcode is instr[3:0]; class is instr[IW-1:4].
- WAIT_W, 4: width of the wait-state counter.
- WAIT_LIMIT, 15: stall cycles allowed before a bus error. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  1 = CPU in RUN state; 0 freezes the sequencer
- instr  in  IW  IR output
- z  in  1  zero flag
- mem_ready  in  1  memory access completes this cycle
- beat  out  8  one-hot: [0]=F1 [1]=F2 [2]=F3 [3..7]=E1..E5
- ar_load, ar_inc, pc_load, pc_inc, dr_load, ir_load, tr_load, r_load, ac_load, ac_load_r, z_load  out  1 each  register strobes
- pc_bus, drl_bus, drh_bus, tr_bus, r_bus, ac_bus  out  1 each  bus drivers
- mem_read, mem_write  out  1 each  memory strobes
- alus  out  4  ALU select
- instr_done  out  1  pulse in the final beat of each instruction
- halted  out  1  HALT executed
- illegal  out  1  sticky; nonzero class other than HALT decoded
- bus_err  out  1  sticky; wait timeout (optional feature)

Behaviour:
- Reset (rst=1 at posedge):
  - beat=F1; halted, illegal, bus_err, wait counter and z_lat all 0.
  - All strobes are combinational and are 0 whenever run=0, halted=1 or rst=1.
- Advance: beat shifts one position per clk when run=1, halted=0 and no stall. After the instruction_done beat, beat returns to F1.
- Decode is combinational from instr during E beats.
  - Class 0, opcodes 0..F: NOP, LDAC, STAC, MOVAC, MOVR, JUMP, JMPZ, JPNZ, ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT.
  - Class 1, opcode 0: HALT.
  - Anything else: executes as NOP and sets illegal.
- z_lat captures z on the edge leaving F3.
- taken = JUMP | (JMPZ & z_lat) | (JPNZ & !z_lat).
- Microcode:
  - F1: pc_bus, ar_load.
  - F2: mem_read, dr_load, pc_inc.
  - F3: pc_bus, ar_load, ir_load.
  - LDAC:
    - E1: mem_read, dr_load, ar_inc, pc_inc.
    - E2: mem_read, dr_load, tr_load, pc_inc.
    - E3: drh_bus, tr_bus, ar_load.
    - E4: mem_read, dr_load.
    - E5: drl_bus, ac_load, alus=8, done.
  - STAC:
    - E1–E3: same as LDAC.
    - E4: ac_bus, dr_load.
    - E5: drl_bus, mem_write, done.
  - Jumps, taken:
    - E1: mem_read, dr_load, ar_inc.
    - E2: mem_read, dr_load, tr_load.
    - E3: drh_bus, tr_bus, pc_load, done.
  - Jumps, not taken:
    - E1: no strobes.
    - E2: pc_inc.
    - E3: pc_inc, done.
  - Single-beat instructions (E1 is the done beat):
    - NOP: no strobes.
    - MOVAC: ac_bus, r_load.
    - MOVR: r_bus, ac_load_r.
    - ALU ops: ac_load, z_load; r_bus also for ADD, SUB, AND, OR, XOR.
    - alus codes: CLAC 0, ADD 1, SUB 2, INAC 3, AND 4, OR 5, NOT 6, XOR 7.
    - HALT: sets halted at the end of E1; instr_done pulses.
  - alus=0 in every beat not listed.
- Memory beats are any beat asserting mem_read or mem_write.
  - When mem_ready=0 in a memory beat: beat holds.
  - mem_read/mem_write stay asserted during the stall.
  - Every other strobe in that beat is suppressed until the cycle in which mem_ready=1.
- run=0 mid-instruction: beat holds and strobes are 0; execution resumes at the same beat when run returns to 1.
- Exit from halted: rst only.

Optional Feature:
- CTRL_WAIT_TIMEOUT_EN defined:
  - The wait counter increments on each stalled cycle and clears on any advance.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: bus_err is set, beat is forced to F1, and no strobes fire in that cycle.
- Undefined: stalls are unbounded and bus_err is tied to 0.

Test Plan:
- Reset, then run=1 with instr=0x01 (LDAC) and mem_ready=1 → beats F1..E5 in 8 cycles; alus=8 with ac_load in E5; instr_done pulses once; beat returns to F1.
- instr=0x06 (JMPZ), z=1 at F3 then z=0 during E1 → taken: pc_load in E3; total 6 cycles.
- STAC with mem_ready=0 for 3 cycles at E1 → beat holds at E1 with mem_read=1 and pc_inc/ar_inc=0; the instruction completes in 11 cycles.
- instr=0x10 (HALT) → halted=1 after E1, all strobes 0 on subsequent cycles; rst clears it. instr=0x20 → executes as NOP and illegal=1.
- run dropped at E2 for 4 cycles → beat stays E2 with strobes 0; resumes correctly.
- With CTRL_WAIT_TIMEOUT_EN: mem_ready=0 held at F2 → bus_err=1 after 15 stalled cycles; beat=F1.
